// File: rtl/health_pkg.sv
// Shared types, widths and colour defaults for the player-health manager and HUD bar.
package health_pkg;

    localparam int unsigned HEALTH_W = 4;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned RGB_W    = 12;

    localparam logic [RGB_W-1:0] RGB_OK_DEF  = 12'hFFF;
    localparam logic [RGB_W-1:0] RGB_LOW_DEF = 12'hF00;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_e;

    typedef struct packed {
        logic             en;
        logic [RGB_W-1:0] rgb;
    } bar_pix_t;

    // +1 that never exceeds the configured maximum
    function automatic logic [HEALTH_W-1:0] sat_inc(input logic [HEALTH_W-1:0] h,
                                                    input logic [HEALTH_W-1:0] max_h);
        return (h >= max_h) ? max_h : h + HEALTH_W'(1);
    endfunction

endpackage

// File: rtl/health_seg_decode.sv
// Combinational hit-test of pixel (x, y) against the lit segments of the health bar.
module health_seg_decode
    import health_pkg::*;
#(
    parameter int unsigned MAX_HEALTH = 3,
    parameter int unsigned SEG_W      = 60,
    parameter int unsigned BAR_X0     = 420,
    parameter int unsigned BAR_Y0     = 460,
    parameter int unsigned BAR_H      = 11
) (
    input  logic [COORD_W-1:0]  x_i,
    input  logic [COORD_W-1:0]  y_i,
    input  logic [HEALTH_W-1:0] health_i,
    output logic                lit_c
);

    // One extra bit so the right edge of the last segment cannot overflow
    localparam int unsigned CMP_W = COORD_W + 1;
    localparam logic [CMP_W-1:0] Y_LO = CMP_W'(BAR_Y0);
    localparam logic [CMP_W-1:0] Y_HI = CMP_W'(BAR_Y0 + BAR_H);

    logic [CMP_W-1:0] x_w;
    logic [CMP_W-1:0] y_w;
    logic             in_row;

    assign x_w    = {1'b0, x_i};
    assign y_w    = {1'b0, y_i};
    assign in_row = (y_w >= Y_LO) && (y_w < Y_HI);

    always_comb begin
        lit_c = 1'b0;
        for (int unsigned k = 0; k < MAX_HEALTH; k++) begin
            if (in_row && (health_i > HEALTH_W'(k)) &&
                (x_w >= CMP_W'(BAR_X0 + k * SEG_W)) &&
                (x_w <  CMP_W'(BAR_X0 + (k + 1) * SEG_W))) begin
                lit_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/health_bar_ctrl.sv
// Player health FSM (ALIVE/INVULN/DEAD) plus registered HUD bar pixel output.
// Optional HEALTH_BLINK_EN: blink the bar in BLINK_FRAMES windows while invulnerable.
module health_bar_ctrl
    import health_pkg::*;
#(
    parameter int unsigned      MAX_HEALTH    = 3,
    parameter int unsigned      SEG_W         = 60,
    parameter int unsigned      BAR_X0        = 420,
    parameter int unsigned      BAR_Y0        = 460,
    parameter int unsigned      BAR_H         = 11,
    parameter int unsigned      INVULN_FRAMES = 60,
    parameter int unsigned      BLINK_FRAMES  = 8,
    parameter logic [RGB_W-1:0] RGB_OK        = RGB_OK_DEF,
    parameter logic [RGB_W-1:0] RGB_LOW       = RGB_LOW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic                frame_tick,
    input  logic                hit,
    input  logic                heal,
    input  logic                restart,
    output logic [HEALTH_W-1:0] health,
    output logic                dead,
    output logic                invuln,
    output logic                bar_en,
    output logic [RGB_W-1:0]    bar_rgb
);

    localparam logic [HEALTH_W-1:0] MAX_H    = HEALTH_W'(MAX_HEALTH);
    localparam int unsigned         INV_W    = $clog2(INVULN_FRAMES + 1);
    localparam logic [INV_W-1:0]    INV_LAST = INV_W'(INVULN_FRAMES - 1);

    state_e              state_q,   state_d;
    logic [HEALTH_W-1:0] health_q,  health_d;
    logic [INV_W-1:0]    inv_cnt_q, inv_cnt_d;
    logic                dead_q,    dead_d;
    logic                invuln_q,  invuln_d;
    bar_pix_t            pix_q,     pix_d;
    logic                seg_lit_c;
    logic                bar_vis_c;

    // Next-state: restart wins, then per-state hit/heal/frame handling
    always_comb begin
        state_d   = state_q;
        health_d  = health_q;
        inv_cnt_d = inv_cnt_q;
        if (restart) begin
            state_d   = ALIVE;
            health_d  = MAX_H;
            inv_cnt_d = '0;
        end else begin
            case (state_q)
                ALIVE: begin
                    if (hit) begin
                        if (health_q > HEALTH_W'(1)) begin
                            health_d  = health_q - HEALTH_W'(1);
                            state_d   = INVULN;
                            inv_cnt_d = '0;
                        end else begin
                            health_d = '0;
                            state_d  = DEAD;
                        end
                    end else if (heal) begin
                        health_d = sat_inc(health_q, MAX_H);
                    end
                end
                INVULN: begin
                    if (heal) begin
                        health_d = sat_inc(health_q, MAX_H);
                    end
                    if (frame_tick) begin
                        if (inv_cnt_q == INV_LAST) begin
                            state_d   = ALIVE;
                            inv_cnt_d = '0;
                        end else begin
                            inv_cnt_d = inv_cnt_q + INV_W'(1);
                        end
                    end
                end
                DEAD: begin
                end
                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
        dead_d   = (state_d == DEAD);
        invuln_d = (state_d == INVULN);
    end

`ifdef HEALTH_BLINK_EN
    localparam int unsigned      BLK_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_ph_q,  blink_ph_d;

    // Phase restarts visible on every INVULN entry; toggles every BLINK_FRAMES ticks
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if ((state_q != INVULN) || (state_d != INVULN)) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign bar_vis_c = !((state_q == INVULN) && blink_ph_q);
`else
    assign bar_vis_c = 1'b1;
`endif

    health_seg_decode #(
        .MAX_HEALTH (MAX_HEALTH),
        .SEG_W      (SEG_W),
        .BAR_X0     (BAR_X0),
        .BAR_Y0     (BAR_Y0),
        .BAR_H      (BAR_H)
    ) u_seg_decode (
        .x_i      (x),
        .y_i      (y),
        .health_i (health_q),
        .lit_c    (seg_lit_c)
    );

    // Pixel colour uses the health of the same cycle as x/y
    always_comb begin
        pix_d = '0;
        if (seg_lit_c && bar_vis_c) begin
            pix_d.en  = 1'b1;
            pix_d.rgb = (health_q == HEALTH_W'(1)) ? RGB_LOW : RGB_OK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ALIVE;
            health_q  <= MAX_H;
            inv_cnt_q <= '0;
            dead_q    <= 1'b0;
            invuln_q  <= 1'b0;
            pix_q     <= '0;
        end else begin
            state_q   <= state_d;
            health_q  <= health_d;
            inv_cnt_q <= inv_cnt_d;
            dead_q    <= dead_d;
            invuln_q  <= invuln_d;
            pix_q     <= pix_d;
        end
    end

    assign health  = health_q;
    assign dead    = dead_q;
    assign invuln  = invuln_q;
    assign bar_en  = pix_q.en;
    assign bar_rgb = pix_q.rgb;

endmodule

// File: tb/tb_health_bar_ctrl.sv
// Directed bench for health_bar_ctrl: per-cycle model comparison plus literal spot checks.
module tb_health_bar_ctrl;

    localparam int MAXH   = 3;
    localparam int SEGW   = 60;
    localparam int X0     = 420;
    localparam int Y0     = 460;
    localparam int BH     = 11;
    localparam int INVF   = 60;
    localparam int BLINKF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic        frame_tick, hit, heal, restart;
    logic [3:0]  health;
    logic        dead, invuln, bar_en;
    logic [11:0] bar_rgb;

    int checks = 0;
    int errors = 0;

    health_bar_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .hit        (hit),
        .heal       (heal),
        .restart    (restart),
        .health     (health),
        .dead       (dead),
        .invuln     (invuln),
        .bar_en     (bar_en),
        .bar_rgb    (bar_rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: mode 0=alive 1=invulnerable 2=dead; frames = ticks since becoming invulnerable
    int          m_health, m_mode, m_frames;
    logic        m_valid = 1'b0;
    logic        e_en;
    logic [11:0] e_rgb;

    function automatic logic model_lit(input int px, input int py, input int h);
        int seg;
        if (py < Y0 || py >= Y0 + BH || px < X0) return 1'b0;
        seg = (px - X0) / SEGW;
        return (seg < MAXH) && (seg < h);
    endfunction

    function automatic logic model_visible(input int mode, input int frames);
`ifdef HEALTH_BLINK_EN
        return !(mode == 1 && ((frames / BLINKF) % 2 == 1));
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (rst) begin
            m_health = MAXH; m_mode = 0; m_frames = 0;
            e_en = 1'b0; e_rgb = 12'h000;
        end else begin
            e_en  = model_lit(int'(x), int'(y), m_health) && model_visible(m_mode, m_frames);
            e_rgb = e_en ? ((m_health == 1) ? 12'hF00 : 12'hFFF) : 12'h000;
            if (restart) begin
                m_health = MAXH; m_mode = 0; m_frames = 0;
            end else if (m_mode == 0) begin
                if (hit) begin
                    m_health = m_health - 1;
                    m_mode   = (m_health == 0) ? 2 : 1;
                    m_frames = 0;
                end else if (heal && m_health < MAXH) begin
                    m_health = m_health + 1;
                end
            end else if (m_mode == 1) begin
                if (heal && m_health < MAXH) m_health = m_health + 1;
                if (frame_tick) begin
                    m_frames = m_frames + 1;
                    if (m_frames == INVF) m_mode = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_health",  32'(health),  32'(m_health));
            chk("cmp_dead",    32'(dead),    32'(m_mode == 2));
            chk("cmp_invuln",  32'(invuln),  32'(m_mode == 1));
            chk("cmp_bar_en",  32'(bar_en),  32'(e_en));
            chk("cmp_bar_rgb", 32'(bar_rgb), 32'(e_rgb));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; @(negedge clk);
            frame_tick = 1'b0; @(negedge clk);
        end
    endtask

    task automatic pulse(input logic h, input logic he, input logic r);
        hit = h; heal = he; restart = r;
        @(negedge clk);
        hit = 1'b0; heal = 1'b0; restart = 1'b0;
    endtask

    task automatic pix(input int px, input int py, input logic exp_en, input logic [11:0] exp_rgb,
                       input string name);
        x = 10'(px); y = 10'(py);
        @(negedge clk);
        chk({name, "_en"},  32'(bar_en),  32'(exp_en));
        chk({name, "_rgb"}, 32'(bar_rgb), 32'(exp_rgb));
    endtask

    int          scan_x [8] = '{419, 420, 479, 480, 539, 540, 599, 600};
    logic        scan_e [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rst = 1'b1; x = 10'd500; y = 10'd465;
        frame_tick = 1'b0; hit = 1'b0; heal = 1'b0; restart = 1'b0;
        idle(3);
        chk("rst_health", 32'(health), 32'd3);
        chk("rst_dead",   32'(dead),   32'd0);
        chk("rst_invuln", 32'(invuln), 32'd0);
        chk("rst_bar_en", 32'(bar_en), 32'd0);
        chk("rst_rgb",    32'(bar_rgb), 32'd0);
        rst = 1'b0;
        idle(2);

        // 1: three spaced hits
        pulse(1, 0, 0);
        chk("t1_h2", 32'(health), 32'd2);
        chk("t1_inv1", 32'(invuln), 32'd1);
        frames(59);
        chk("t1_inv_59", 32'(invuln), 32'd1);
        frames(1);
        chk("t1_inv_60", 32'(invuln), 32'd0);
        pulse(1, 0, 0);
        chk("t1_h1", 32'(health), 32'd1);
        chk("t1_inv2", 32'(invuln), 32'd1);
        frames(60);
        pulse(1, 0, 0);
        chk("t1_h0", 32'(health), 32'd0);
        chk("t1_dead", 32'(dead), 32'd1);
        chk("t1_inv3", 32'(invuln), 32'd0);

        // 2: hit during invulnerability ignored
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        frames(10);
        pulse(1, 0, 0);
        chk("t2_ignored", 32'(health), 32'd2);
        frames(50);
        chk("t2_inv_end", 32'(invuln), 32'd0);
        pulse(1, 0, 0);
        chk("t2_h1", 32'(health), 32'd1);

        // 3: heal saturation, heal in INVULN, hit+heal priority, DEAD ignores events
        pulse(0, 0, 1);
        pulse(0, 1, 0);
        chk("t3_sat", 32'(health), 32'd3);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("t3_inv_heal", 32'(health), 32'd3);
        frames(60);
        pulse(1, 0, 0);
        frames(60);
        pulse(1, 0, 0);
        frames(60);
        chk("t3_h1", 32'(health), 32'd1);
        pulse(1, 1, 0);
        chk("t3_hh_dead", 32'(dead), 32'd1);
        chk("t3_hh_h0", 32'(health), 32'd0);
        pulse(0, 1, 0);
        chk("t3_dead_heal", 32'(health), 32'd0);

        // 4: segment edges at health 2
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        frames(60);
        for (int i = 0; i < 8; i++)
            pix(scan_x[i], 460, scan_e[i], scan_e[i] ? 12'hFFF : 12'h000, $sformatf("t4_x%0d", scan_x[i]));
        for (int i = 0; i < 8; i++)
            pix(scan_x[i], 471, 1'b0, 12'h000, $sformatf("t4_y471_x%0d", scan_x[i]));
        pix(430, 470, 1'b1, 12'hFFF, "t4_bottom");
        pix(430, 459, 1'b0, 12'h000, "t4_above");

        // 5: low-health colour
        x = 10'd430; y = 10'd465;
        pulse(1, 0, 0);
        pix(430, 465, 1'b1, 12'hF00, "t5_low");
        pulse(0, 1, 0);
        pix(430, 465, 1'b1, 12'hFFF, "t5_ok");

        // 6: restart beats hit from DEAD, then blink pattern
        frames(60);
        pulse(1, 0, 0);
        frames(60);
        pulse(1, 0, 0);
        chk("t6_dead", 32'(dead), 32'd1);
        pulse(1, 0, 1);
        chk("t6_h3", 32'(health), 32'd3);
        chk("t6_inv", 32'(invuln), 32'd0);
        chk("t6_alive", 32'(dead), 32'd0);
        pulse(1, 0, 0);
        for (int f = 0; f < 20; f++) begin
            idle(1);
`ifdef HEALTH_BLINK_EN
            chk($sformatf("t6_blink_f%0d", f), 32'(bar_en), 32'(((f / BLINKF) % 2) == 0));
`else
            chk($sformatf("t6_steady_f%0d", f), 32'(bar_en), 32'd1);
`endif
            frames(1);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
